load_store_unit: RTL

Memory stage of the RISC-V core, directly downstream of the control unit. It consumes the control unit's memory strobes and size codes together with the ALU-computed address and rs2 data. It runs one load or store at a time over a req/gnt/rvalid data-memory port, and stalls the pipeline while that access is outstanding. It handles byte-lane alignment, misalignment detection, load sign/zero extension and a bus timeout.

---
 rtl/load_store_unit.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Memory stage: runs one load or store at a time over a req/gnt/rvalid port.
// Handles byte-lane placement, misalignment faults, load extension and a bus timeout.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ctrl_mem_write,
  input  logic        ctrl_mem2reg,
  input  logic [2:0]  ctrl_load_size,
  input  logic [2:0]  ctrl_store_size,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd_addr,
  output logic        lsu_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        load_valid,
  output logic [31:0] load_data,
  output logic [4:0]  load_rd,
  output logic        misaligned,
  output logic        bus_err
);

  // state  | meaning
  // IDLE   | no access outstanding, checking strobes
  // REQ    | mem_req held until mem_gnt
  // WAIT_R | load granted, waiting for mem_rvalid
  typedef enum logic [1:0] {IDLE, REQ, WAIT_R} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic        is_store, access, size_ok, aligned, fault, accept;
  logic [2:0]  size;
  logic [1:0]  off;
  logic [3:0]  be_nxt;
  logic [31:0] wdata_nxt;
  logic        tmo_hit, timeout, done;
  logic [15:0] tmo_cnt;
  logic [2:0]  ld_size_q;
  logic [1:0]  off_q;
  logic [4:0]  rd_q;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ext_data;

  always_comb begin
    is_store = ctrl_mem_write;
    access   = ctrl_mem_write | ctrl_mem2reg;
    size     = is_store ? ctrl_store_size : ctrl_load_size;
    off      = addr[1:0];
    size_ok  = is_store ? (size < 3'b011) : !((size[1:0] == 2'b11) || (size == 3'b110));
    case (size[1:0])
      2'b01:   aligned = !off[0];
      2'b10:   aligned = (off == 2'b00);
      default: aligned = 1'b1;
    endcase
    fault  = (state == IDLE) && access && !(size_ok && aligned);
    accept = (state == IDLE) && access && size_ok && aligned;
    case (size[1:0])
      2'b00: begin
        be_nxt    = 4'b0001 << off;
        wdata_nxt = {4{store_data[7:0]}};
      end
      2'b01: begin
        be_nxt    = 4'b0011 << off;
        wdata_nxt = {2{store_data[15:0]}};
      end
      default: begin
        be_nxt    = 4'b1111;
        wdata_nxt = store_data;
      end
    endcase
  end

  assign tmo_hit = (TIMEOUT != 0) && (tmo_cnt == TMO_LAST);

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE: if (accept) state_nxt = REQ;
      REQ: begin
        if (mem_gnt) begin
          if (mem_we) begin
            state_nxt = IDLE;
            done      = 1'b1;
          end else begin
            state_nxt = WAIT_R;
          end
        end else if (tmo_hit) begin
          state_nxt = IDLE;
          done      = 1'b1;
          timeout   = 1'b1;
        end
      end
      WAIT_R: begin
        if (mem_rvalid) begin
          state_nxt = IDLE;
          done      = 1'b1;
        end else if (tmo_hit) begin
          state_nxt = IDLE;
          done      = 1'b1;
          timeout   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // gated by rst_n so the stall drops the instant reset is asserted
    lsu_stall = rst_n && (accept || ((state != IDLE) && !done));
  end

  always_comb begin
    ld_byte = mem_rdata[{off_q, 3'b000} +: 8];
    ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (ld_size_q)
      3'b000:  ext_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ext_data = {24'd0, ld_byte};
      3'b001:  ext_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ext_data = {16'd0, ld_half};
      default: ext_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= '0;
      mem_wdata  <= '0;
      load_valid <= 1'b0;
      load_data  <= '0;
      load_rd    <= '0;
      misaligned <= 1'b0;
      bus_err    <= 1'b0;
      tmo_cnt    <= '0;
      ld_size_q  <= '0;
      off_q      <= '0;
      rd_q       <= '0;
    end else begin
      state      <= state_nxt;
      load_valid <= 1'b0;
      misaligned <= fault;
      bus_err    <= timeout;
      if (accept) begin
        mem_req   <= 1'b1;
        mem_we    <= is_store;
        mem_addr  <= {addr[31:2], 2'b00};
        mem_be    <= be_nxt;
        mem_wdata <= wdata_nxt;
        ld_size_q <= ctrl_load_size;
        off_q     <= off;
        rd_q      <= rd_addr;
        tmo_cnt   <= '0;
      end
      if (state == REQ) begin
        if (mem_gnt) begin
          mem_req <= 1'b0;
          tmo_cnt <= '0;
        end else if (timeout) begin
          mem_req <= 1'b0;
        end else begin
          tmo_cnt <= tmo_cnt + 16'd1;
        end
      end
      if (state == WAIT_R) begin
        if (mem_rvalid) begin
          load_valid <= 1'b1;
          load_data  <= ext_data;
          load_rd    <= rd_q;
        end else if (!timeout) begin
          tmo_cnt <= tmo_cnt + 16'd1;
        end
      end
    end
  end

endmodule
